lsu_sram_slave: RTL and testbench



---
 rtl/lsu_mem_pkg.sv | 22 ++
 rtl/lfsr8.sv | 21 ++
 rtl/lsu_sram_slave.sv | 136 +++++++++++++
 tb/tb_lsu_sram_slave.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_pkg.sv
// Shared definitions for LSU-side memory slaves: FSM states, address map default,
// LFSR feedback taps and the value returned for out-of-range reads.
package lsu_mem_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [31:0] DEFAULT_ADDR_BASE = 32'h8000_0000;

    // x^8 + x^6 + x^5 + x^4 + 1, Fibonacci form shifting left: feedback from q[7,5,4,3]
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam logic [31:0] OOR_RDATA = 32'h0000_0000;

    function automatic logic [7:0] lfsr8_step(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr8.sv
// Seedable 8-bit Fibonacci LFSR with enable; shared by random-latency memory slaves.
module lfsr8
    import lsu_mem_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    output logic [7:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= SEED;
        end else if (en) begin
            q <= lfsr8_step(q);
        end
    end

endmodule

// File: rtl/lsu_sram_slave.sv
// Data-memory slave for the LSU SRAM port: one request per handshake, byte-masked
// writes, and a fixed or LFSR-random response latency ending in a one-cycle ready.
module lsu_sram_slave
    import lsu_mem_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = DEFAULT_ADDR_BASE,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned LAT_MODE    = 0,
    parameter int unsigned FIXED_LAT   = 1,
    parameter logic [7:0]  LAT_MASK    = 8'h07,
    parameter logic [7:0]  LFSR_SEED   = 8'hA5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] sram_addr,
    input  logic        sram_valid,
    output logic        sram_ready,
    output logic [31:0] sram_rdata,
    input  logic [31:0] sram_wdata,
    input  logic [3:0]  sram_wmask,
    input  logic        sram_wen,
    output logic        sram_err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    state_t      state;
    state_t      state_next;
    logic [7:0]  cnt;
    logic [7:0]  cnt_next;
    logic [7:0]  lfsr_q;
    logic [7:0]  lat_load;
    logic        accept;
    logic        fire;

    logic [29:0] req_word;
    logic [31:0] req_wdata;
    logic [3:0]  req_wmask;
    logic        req_wen;

    logic [29:0] word_off;
    logic        in_range;
    logic [IDX_W-1:0] idx;

    logic [31:0] mem [DEPTH_WORDS];

    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^sram_addr[1:0];

    lfsr8 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .en  (1'b1),
        .q   (lfsr_q)
    );

    // Counter holds L-1; the access fires on the edge where it reads zero.
    assign lat_load = (LAT_MODE == 1) ? (lfsr_q & LAT_MASK) : 8'(FIXED_LAT - 1);

    assign word_off = req_word - ADDR_BASE[31:2];
    assign in_range = (req_word >= ADDR_BASE[31:2]) &&
                      ({2'b00, word_off} < 32'(DEPTH_WORDS));
    assign idx      = word_off[IDX_W-1:0];

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        fire       = 1'b0;
        case (state)
            S_IDLE: begin
                if (sram_valid) begin
                    accept     = 1'b1;
                    cnt_next   = lat_load;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == '0) begin
                    fire       = 1'b1;
                    state_next = S_RESP;
                end else begin
                    cnt_next = cnt - 8'd1;
                end
            end
            S_RESP: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            cnt        <= '0;
            sram_ready <= 1'b0;
            sram_err   <= 1'b0;
            sram_rdata <= '0;
            req_word   <= '0;
            req_wdata  <= '0;
            req_wmask  <= '0;
            req_wen    <= 1'b0;
        end else begin
            state      <= state_next;
            cnt        <= cnt_next;
            sram_ready <= fire;
            if (accept) begin
                req_word  <= sram_addr[31:2];
                req_wdata <= sram_wdata;
                req_wmask <= sram_wmask;
                req_wen   <= sram_wen;
            end
            if (fire) begin
                sram_err   <= ~in_range;
                sram_rdata <= in_range ? mem[idx] : OOR_RDATA;
            end
        end
    end

    // No reset on the array; a store still pending when rst rises is dropped.
    always_ff @(posedge clk) begin
        if (!rst && fire && in_range && req_wen) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (req_wmask[b]) begin
                    mem[idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_sram_slave.sv
// Directed and scoreboarded checks of lsu_sram_slave in fixed L=1, fixed L=4 and random modes.
module tb_lsu_sram_slave;

    logic        clk = 1'b0;
    logic [2:0]  rst;
    logic [2:0]  valid;
    logic [2:0]  ready;
    logic [2:0]  err;
    logic [31:0] rdata [3];
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        wen;
    logic [7:0]  m_lfsr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    lsu_sram_slave #(.FIXED_LAT(1)) u_l1 (
        .clk(clk), .rst(rst[0]), .sram_addr(addr), .sram_valid(valid[0]),
        .sram_ready(ready[0]), .sram_rdata(rdata[0]), .sram_wdata(wdata),
        .sram_wmask(wmask), .sram_wen(wen), .sram_err(err[0]));

    lsu_sram_slave #(.FIXED_LAT(4)) u_l4 (
        .clk(clk), .rst(rst[1]), .sram_addr(addr), .sram_valid(valid[1]),
        .sram_ready(ready[1]), .sram_rdata(rdata[1]), .sram_wdata(wdata),
        .sram_wmask(wmask), .sram_wen(wen), .sram_err(err[1]));

    lsu_sram_slave #(.LAT_MODE(1), .LAT_MASK(8'h07), .LFSR_SEED(8'hA5)) u_rnd (
        .clk(clk), .rst(rst[2]), .sram_addr(addr), .sram_valid(valid[2]),
        .sram_ready(ready[2]), .sram_rdata(rdata[2]), .sram_wdata(wdata),
        .sram_wmask(wmask), .sram_wen(wen), .sram_err(err[2]));

    // Reference LFSR for the random instance: x^8+x^6+x^5+x^4+1, seed A5
    always @(posedge clk) begin
        if (rst[2]) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge. lat = edges from the accept edge to the edge raising ready.
    task automatic xfer(input int u, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] m, input logic w, input bit hold_resp,
                        output logic [31:0] rd, output logic e, output int lat);
        int n;
        addr = a; wdata = d; wmask = m; wen = w;
        valid[u] = 1'b1;
        n = 0; rd = '0; e = 1'b0;
        while (1) begin
            @(negedge clk);
            n++;
            if (ready[u] || n >= 40) break;
        end
        lat = n - 1;
        if (!ready[u]) begin
            check_eq("timeout", {31'b0, ready[u]}, 32'd1);
            valid[u] = 1'b0;
            return;
        end
        rd = rdata[u];
        e  = err[u];
        if (!hold_resp) valid[u] = 1'b0;
        @(negedge clk);
        check_eq("ready_pulse", {31'b0, ready[u]}, 32'd0);
        valid[u] = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;
        int          exp_lat;
        int          highs;
        logic [31:0] refm [16];
        logic [31:0] a, d;
        logic [3:0]  m;
        logic        w;
        int          k;

        rst = '1; valid = '0; addr = '0; wdata = '0; wmask = '0; wen = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = '0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check_eq("rst_ready", {31'b0, ready[i]}, 32'd0);
            check_eq("rst_err",   {31'b0, err[i]},   32'd0);
            check_eq("rst_rdata", rdata[i],          32'd0);
        end

        // Fixed L=1
        xfer(0, 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0, rd, e, lat);
        check_eq("l1_st_lat", 32'(lat), 32'd1);
        check_eq("l1_st_err", {31'b0, e}, 32'd0);
        xfer(0, 32'h8000_0010, 32'h0, 4'h0, 1'b0, 1'b0, rd, e, lat);
        check_eq("l1_ld_lat", 32'(lat), 32'd1);
        check_eq("l1_ld_data", rd, 32'hDEAD_BEEF);
        check_eq("l1_ld_err", {31'b0, e}, 32'd0);

        // Byte mask and empty mask
        xfer(0, 32'h8000_0020, 32'h1122_3344, 4'hF, 1'b1, 1'b0, rd, e, lat);
        xfer(0, 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 1'b1, 1'b0, rd, e, lat);
        xfer(0, 32'h8000_0020, 32'h0, 4'h0, 1'b0, 1'b0, rd, e, lat);
        check_eq("mask_data", rd, 32'h11BB_33DD);
        xfer(0, 32'h8000_0020, 32'hFFFF_FFFF, 4'h0, 1'b1, 1'b0, rd, e, lat);
        check_eq("mask0_err", {31'b0, e}, 32'd0);
        xfer(0, 32'h8000_0020, 32'h0, 4'h0, 1'b0, 1'b0, rd, e, lat);
        check_eq("mask0_data", rd, 32'h11BB_33DD);

        // Range boundaries
        xfer(0, 32'h8000_0000, 32'h0102_0304, 4'hF, 1'b1, 1'b0, rd, e, lat);
        xfer(0, 32'h8000_3FFC, 32'hCAFE_F00D, 4'hF, 1'b1, 1'b0, rd, e, lat);
        check_eq("last_err", {31'b0, e}, 32'd0);
        xfer(0, 32'h7FFF_FFFC, 32'h0, 4'h0, 1'b0, 1'b0, rd, e, lat);
        check_eq("oor_lo_err", {31'b0, e}, 32'd1);
        check_eq("oor_lo_data", rd, 32'd0);
        xfer(0, 32'h8000_4000, 32'h0, 4'h0, 1'b0, 1'b0, rd, e, lat);
        check_eq("oor_hi_err", {31'b0, e}, 32'd1);
        check_eq("oor_hi_data", rd, 32'd0);
        xfer(0, 32'h7FFF_FFFC, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, rd, e, lat);
        check_eq("oor_st_lo_err", {31'b0, e}, 32'd1);
        xfer(0, 32'h8000_4000, 32'hFFFF_FFFF, 4'hF, 1'b1, 1'b0, rd, e, lat);
        check_eq("oor_st_hi_err", {31'b0, e}, 32'd1);
        xfer(0, 32'h8000_3FFC, 32'h0, 4'h0, 1'b0, 1'b0, rd, e, lat);
        check_eq("keep_last", rd, 32'hCAFE_F00D);
        xfer(0, 32'h8000_0000, 32'h0, 4'h0, 1'b0, 1'b0, rd, e, lat);
        check_eq("keep_first", rd, 32'h0102_0304);
        xfer(0, 32'h8000_0010, 32'h0, 4'h0, 1'b0, 1'b0, rd, e, lat);
        check_eq("keep_10", rd, 32'hDEAD_BEEF);

        // Fixed L=4, valid held through RESP
        xfer(1, 32'h8000_0100, 32'h1234_5678, 4'hF, 1'b1, 1'b1, rd, e, lat);
        check_eq("l4_st_lat", 32'(lat), 32'd4);
        highs = 0;
        repeat (8) begin @(negedge clk); if (ready[1]) highs++; end
        check_eq("l4_no_second", 32'(highs), 32'd0);
        xfer(1, 32'h8000_0100, 32'h0, 4'h0, 1'b0, 1'b0, rd, e, lat);
        check_eq("l4_ld_lat", 32'(lat), 32'd4);
        check_eq("l4_ld_data", rd, 32'h1234_5678);

        // Reset while a store waits
        addr = 32'h8000_0100; wdata = 32'hFFFF_FFFF; wmask = 4'hF; wen = 1'b1;
        valid[1] = 1'b1;
        highs = 0;
        @(negedge clk); if (ready[1]) highs++;
        @(negedge clk); if (ready[1]) highs++;
        rst[1] = 1'b1; valid[1] = 1'b0;
        @(negedge clk); if (ready[1]) highs++;
        rst[1] = 1'b0;
        repeat (8) begin @(negedge clk); if (ready[1]) highs++; end
        check_eq("rstw_no_ready", 32'(highs), 32'd0);
        xfer(1, 32'h8000_0100, 32'h0, 4'h0, 1'b0, 1'b0, rd, e, lat);
        check_eq("rstw_lat", 32'(lat), 32'd4);
        check_eq("rstw_data", rd, 32'h1234_5678);
        check_eq("rstw_err", {31'b0, e}, 32'd0);

        // Random latency with scoreboard
        for (int i = 0; i < 16; i++) begin
            refm[i] = 32'h5A00_0000 + 32'(i);
            xfer(2, 32'h8000_0000 + 32'(4 * i), refm[i], 4'hF, 1'b1, 1'b0, rd, e, lat);
        end
        for (int i = 0; i < 1000; i++) begin
            k = $urandom_range(0, 15);
            a = 32'h8000_0000 + 32'(4 * k);
            d = $urandom;
            m = 4'($urandom_range(0, 15));
            w = 1'($urandom_range(0, 1));
            exp_lat = 1 + int'(m_lfsr & 8'h07);
            xfer(2, a, d, m, w, 1'b0, rd, e, lat);
            check_eq("rnd_lat_range", {31'b0, (lat >= 1 && lat <= 8)}, 32'd1);
            check_eq("rnd_lat_seq", 32'(lat), 32'(exp_lat));
            check_eq("rnd_err", {31'b0, e}, 32'd0);
            if (w) begin
                for (int b = 0; b < 4; b++)
                    if (m[b]) refm[k][8*b +: 8] = d[8*b +: 8];
            end else begin
                check_eq("rnd_ld_data", rd, refm[k]);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
